ex_muldiv: RTL and testbench
============================

Name: ex_muldiv

Overview:
- Iterative multiply/divide unit in the EX stage, fed by the ID_EX pipeline register outputs (bus_a, bus_b, decoded op).
- Executes MULT/MULTU/DIV/DIVU into architectural HI/LO and services MTHI/MTLO.
- Raises a stall toward the hazard unit, which drops the ID_EX enable, while a result is pending and a dependent or new mul/div op arrives.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  pipeline advance qualifier (same signal as the ID_EX enable); an op is accepted only when high.
- op  input  3  000 NONE, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (treated as NONE).
- mfhilo_req  input  1  the instruction in EX is MFHI/MFLO.
- bus_a_in  input  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO data).
- bus_b_in  input  WIDTH  rt operand (multiplier / divisor).
- hi_out  output  WIDTH  HI register.
- lo_out  output  WIDTH  LO register.
- busy  output  1  high while state is not IDLE.
- stall  output  1  busy AND (mfhilo_req OR op not NONE).
- done  output  1  one-cycle pulse in the cycle after HI/LO update.
- div_by_zero  output  1  one-cycle pulse coincident with done for a DIV/DIVU with zero divisor.

Behaviour:
- Reset (asynchronous, active-low):
  - state IDLE; hi_out, lo_out and all internal registers 0.
  - busy, stall, done and div_by_zero are 0.
  - Applies immediately, including mid-operation; the in-flight op is discarded.
- FSM states: IDLE, RUN, FIX.
- IDLE:
  - Acceptance at a clock edge requires enable=1 and op not NONE.
  - MTHI/MTLO write hi_out/lo_out at that edge with bus_a_in, then stay in IDLE (latency 1, busy never asserts).
  - MULT/MULTU/DIV/DIVU latch operands. For signed ops, magnitudes and result sign flags are captured. The iteration counter is loaded with WIDTH, then the FSM enters RUN.
  - DIV/DIVU with bus_b_in=0 goes directly to FIX with the zero-divide flag set.
- RUN: one shift-add (multiply) or restoring subtract-shift (divide) step per cycle; the counter decrements. When the counter reaches 0 the FSM moves to FIX.
- FIX:
  - Apply sign correction. The signed product is negated when the operand signs differ. The signed quotient is truncated toward zero; the remainder takes the dividend's sign.
  - Write {HI,LO} (multiply: HI=upper half, LO=lower half; divide: LO=quotient, HI=remainder), return to IDLE, and pulse done next cycle.
  - Zero divide: HI/LO unchanged; done and div_by_zero pulse.
- Latency: busy is high for WIDTH+1 cycles after the accept edge (for WIDTH=32, 33 cycles). Zero divide: 1 cycle.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF yields LO=0x80000000, HI=0 (wrap, no trap).
- While busy:
  - Any op is ignored, not queued. stall holds the pipeline so the op is re-presented.
  - mfhilo_req stalls until busy falls. In the done cycle stall=0 and the new HI/LO are visible.
- enable=0: no op is accepted; an in-flight operation continues.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN, multiply only; divide latency is unchanged.
- Defined:
  - After each RUN step of MULT/MULTU, the FSM goes to FIX as soon as the remaining multiplier magnitude is 0.
  - A zero multiplier magnitude at accept goes directly to FIX.
  - Busy cycles = (index of highest set bit of |b|)+1, plus 1; |b|=0 gives 1 cycle.
- Undefined: fixed WIDTH+1 cycle latency for all multiplies.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> busy 33 cycles; HI=0xFFFFFFFE, LO=0x00000001; one done pulse.
- MULT 0xFFFFFFFD(-3) × 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; then DIVU 100/7 -> LO=14, HI=2.
- DIV 0xFFFFFFF9(-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- HI=LO=0x1234, DIV x/0 -> busy 1 cycle; done and div_by_zero pulse together; HI/LO stay 0x1234.
- MULT in flight, present mfhilo_req=1 plus MTLO 0xAA -> stall=1 until busy drops; product visible in the done cycle; MTLO then writes LO=0xAA.
- Reset low at RUN cycle 10 -> all outputs 0 immediately. With MULDIV_EARLY_OUT_EN, MULTU 5×3 -> busy 3 cycles, LO=15.

Source files
------------

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO.
// Define MULDIV_EARLY_OUT_EN to end multiplies once the remaining multiplier is zero.
module ex_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [2:0]       op,
    input  logic             mfhilo_req,
    input  logic [WIDTH-1:0] bus_a_in,
    input  logic [WIDTH-1:0] bus_b_in,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [2:0] OP_MULT = 3'd1, OP_MULTU = 3'd2, OP_DIV = 3'd3, OP_DIVU = 3'd4;
    localparam logic [2:0] OP_MTHI = 3'd5, OP_MTLO = 3'd6;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t state, state_next;

    logic [2*WIDTH-1:0] acc, mc, mul_acc, acc_div, prod;
    logic [WIDTH-1:0]   mp, a_mag, b_mag, div_r, quo_f, rem_f;
    logic [WIDTH:0]     div_t;
    logic [CW-1:0]      cnt;
    logic is_div, neg_q, neg_r, dz;
    logic op_valid, is_md, div_op, sgn_op, a_neg, b_neg, accept, div_ge, zero_start, early;

    always_comb begin
        op_valid = op != 3'd0 && op != 3'd7;
        is_md    = op >= OP_MULT && op <= OP_DIVU;
        div_op   = op == OP_DIV || op == OP_DIVU;
        sgn_op   = op == OP_MULT || op == OP_DIV;
        a_neg    = sgn_op && bus_a_in[WIDTH-1];
        b_neg    = sgn_op && bus_b_in[WIDTH-1];
        a_mag    = a_neg ? -bus_a_in : bus_a_in;
        b_mag    = b_neg ? -bus_b_in : bus_b_in;
        accept   = state == IDLE && enable && op_valid;
        mul_acc  = mp[0] ? acc + mc : acc;
        // Restoring divide: {rem, quo} lives in acc, the divisor in mc's low half.
        div_t    = acc[2*WIDTH-1:WIDTH-1];
        div_ge   = div_t >= {1'b0, mc[WIDTH-1:0]};
        div_r    = div_t[WIDTH-1:0] - mc[WIDTH-1:0];
        acc_div  = div_ge ? {div_r, acc[WIDTH-2:0], 1'b1} : {acc[2*WIDTH-2:0], 1'b0};
        prod     = neg_q ? -acc : acc;
        quo_f    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_f    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
`ifdef MULDIV_EARLY_OUT_EN
        zero_start = bus_b_in == '0;
        early      = !is_div && mp[WIDTH-1:1] == '0;
`else
        zero_start = div_op && bus_b_in == '0;
        early      = 1'b0;
`endif
        busy  = state != IDLE;
        stall = busy && (mfhilo_req || op_valid);
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept && is_md) state_next = zero_start ? FIX : RUN;
            RUN:     if (cnt == CW'(1) || early) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            acc         <= '0;
            mc          <= '0;
            mp          <= '0;
            cnt         <= '0;
            is_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dz          <= 1'b0;
            hi_out      <= '0;
            lo_out      <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= state_next;
            done        <= state == FIX;
            div_by_zero <= state == FIX && dz;
            if (accept) begin
                if (op == OP_MTHI) hi_out <= bus_a_in;
                if (op == OP_MTLO) lo_out <= bus_a_in;
                is_div <= div_op;
                neg_q  <= a_neg ^ b_neg;
                neg_r  <= a_neg;
                dz     <= div_op && bus_b_in == '0;
                cnt    <= CW'(WIDTH);
                mp     <= b_mag;
                acc    <= div_op ? {{WIDTH{1'b0}}, a_mag} : '0;
                mc     <= {{WIDTH{1'b0}}, div_op ? b_mag : a_mag};
            end
            if (state == RUN) begin
                acc <= is_div ? acc_div : mul_acc;
                mc  <= is_div ? mc : mc << 1;
                mp  <= mp >> 1;
                cnt <= cnt - CW'(1);
            end
            if (state == FIX && !dz) {hi_out, lo_out} <= is_div ? {rem_f, quo_f} : prod;
        end
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: random and directed checks of ex_muldiv against an arithmetic reference model.
module tb_ex_muldiv;
    localparam logic [2:0] NONE = 3'd0, MULT = 3'd1, MULTU = 3'd2, DIV = 3'd3, DIVU = 3'd4;
    localparam logic [2:0] MTHI = 3'd5, MTLO = 3'd6, RSVD = 3'd7;

    logic        clk = 1'b0, rst_n = 1'b1, enable = 1'b0, mfhilo_req = 1'b0;
    logic [2:0]  op = NONE;
    logic [31:0] bus_a = '0, bus_b = '0, hi, lo;
    logic        busy, stall, done, dbz;
    logic [31:0] mhi = '0, mlo = '0;
    int          n_cmp = 0, n_err = 0;

    ex_muldiv #(.WIDTH(32)) dut (
        .clk(clk), .reset(rst_n), .enable(enable), .op(op), .mfhilo_req(mfhilo_req),
        .bus_a_in(bus_a), .bus_b_in(bus_b), .hi_out(hi), .lo_out(lo),
        .busy(busy), .stall(stall), .done(done), .div_by_zero(dbz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Architectural result and busy length of one op, from plain integer arithmetic.
    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el,
                         output logic edz, output int cyc);
        longint sa, sb, m;
        logic [63:0] p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        eh = mhi; el = mlo; edz = 1'b0; cyc = 0;
        case (o)
            MULT, MULTU: begin
                p = (o == MULT) ? 64'(sa * sb) : {32'b0, a} * {32'b0, b};
                {eh, el} = p;
                m = (o == MULT) ? (sb < 0 ? -sb : sb) : longint'({32'b0, b});
`ifdef MULDIV_EARLY_OUT_EN
                cyc = (m == 0) ? 1 : $clog2(m + 1) + 1;
`else
                cyc = 33 + int'(m) * 0;
`endif
            end
            DIV, DIVU: begin
                if (b == 0) begin
                    edz = 1'b1; cyc = 1;
                end else begin
                    q = (o == DIV) ? 64'(sa / sb) : {32'b0, a} / {32'b0, b};
                    r = (o == DIV) ? 64'(sa % sb) : {32'b0, a} % {32'b0, b};
                    el = q[31:0]; eh = r[31:0]; cyc = 33;
                end
            end
            MTHI: eh = a;
            MTLO: el = a;
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh, el;
        logic edz;
        int ecyc, cyc;
        model(o, a, b, eh, el, edz, ecyc);
        @(negedge clk);
        enable = 1'b1; op = o; bus_a = a; bus_b = b;
        @(negedge clk);
        enable = 1'b0; op = NONE; bus_a = $urandom; bus_b = $urandom;
        cyc = 0;
        while (busy && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        check("busy_cycles", 64'(cyc), 64'(ecyc));
        check("done", done, ecyc != 0);
        check("div_by_zero", dbz, edz);
        check("hi", hi, eh);
        check("lo", lo, el);
        mhi = eh; mlo = el;
        if (ecyc != 0) begin
            @(negedge clk);
            check("done_pulse_end", {done, dbz}, 2'b00);
        end
    endtask

    initial begin
        logic [31:0] eh, el, a, b;
        logic edz;
        int ecyc, cyc;
        logic [2:0] o;

        #3 rst_n = 1'b0;
        #1;
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_flags", {busy, stall, done, dbz}, 4'b0000);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_max_hi", hi, 32'hFFFF_FFFE);
        check("multu_max_lo", lo, 32'h0000_0001);
        run_op(MULT, 32'hFFFF_FFFD, 32'd7);
        check("mult_neg_lo", lo, 32'hFFFF_FFEB);
        run_op(DIVU, 32'd100, 32'd7);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);
        run_op(DIV, 32'hFFFF_FFF9, 32'd2);
        check("div_neg_lo", lo, 32'hFFFF_FFFD);
        check("div_neg_hi", hi, 32'hFFFF_FFFF);
        run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf_lo", lo, 32'h8000_0000);
        check("div_ovf_hi", hi, 32'h0);
        run_op(MTHI, 32'h1234, 32'h0);
        run_op(MTLO, 32'h1234, 32'h0);
        run_op(DIV, 32'd99, 32'd0);
        check("dz_hi_kept", hi, 32'h1234);
        check("dz_lo_kept", lo, 32'h1234);
        run_op(DIVU, 32'd5, 32'd0);
        run_op(MULTU, 32'd5, 32'd3);
        check("mul5x3_lo", lo, 32'd15);
        run_op(MULT, 32'h1234_5678, 32'd0);
        run_op(MULT, 32'h7FFF_FFFF, 32'h8000_0000);

        // Ops that must not be accepted: enable low, or reserved encoding.
        @(negedge clk);
        enable = 1'b0; op = MTHI; bus_a = 32'hDEAD;
        @(negedge clk);
        check("en0_hi", hi, mhi);
        check("en0_busy", busy, 1'b0);
        op = DIV; bus_b = 32'd3;
        @(negedge clk);
        check("en0_div_busy", busy, 1'b0);
        enable = 1'b1; op = RSVD;
        @(negedge clk);
        check("rsvd_busy", {busy, stall}, 2'b00);
        check("rsvd_hilo", {hi, lo}, {mhi, mlo});
        enable = 1'b0; op = NONE;

        // In-flight MULT with MFHI/MFLO and MTLO presented: stalls, then MTLO lands.
        model(MULT, 32'hFFFF_FFFD, 32'd7, eh, el, edz, ecyc);
        @(negedge clk);
        enable = 1'b1; op = MULT; bus_a = 32'hFFFF_FFFD; bus_b = 32'd7;
        @(negedge clk);
        op = MTLO; bus_a = 32'hAA; bus_b = 32'h0; mfhilo_req = 1'b1;
        cyc = 0;
        while (busy && cyc < 200) begin
            cyc++;
            check("stall_busy", stall, 1'b1);
            @(negedge clk);
        end
        check("stall_cycles", 64'(cyc), 64'(ecyc));
        check("stall_done", {stall, done}, 2'b01);
        check("stall_hi", hi, eh);
        check("stall_lo", lo, el);
        @(negedge clk);
        check("mtlo_after_lo", lo, 32'hAA);
        check("mtlo_after_hi", hi, eh);
        mhi = eh; mlo = 32'hAA;
        enable = 1'b0; op = NONE; mfhilo_req = 1'b0;

        // Asynchronous reset in the middle of a long multiply.
        run_op(MTHI, 32'h5555, 32'h0);
        @(negedge clk);
        enable = 1'b1; op = MULTU; bus_a = 32'hFFFF_FFFF; bus_b = 32'hFFFF_FFFF;
        @(negedge clk);
        enable = 1'b0; op = NONE; mfhilo_req = 1'b1;
        repeat (9) @(negedge clk);
        check("pre_rst_stall", {busy, stall}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_hilo", {hi, lo}, 64'h0);
        check("mid_rst_flags", {busy, stall, done, dbz}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1; mfhilo_req = 1'b0;
        mhi = '0; mlo = '0;
        @(negedge clk);
        check("post_rst_busy", busy, 1'b0);

        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(1, 6));
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'h0;
                1: b = $urandom_range(0, 20);
                2: b = -$urandom_range(1, 20);
                default: b = $urandom;
            endcase
            run_op(o, a, b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
